// File: rtl/answer_checker.sv
// Player-answer path for the math game: synchronises switch/submit, debounces the button,
// decodes the two-digit BCD entry and scores it against the latched target.
module answer_checker #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SHOW_CYCLES     = 8,
  parameter int SCORE_W         = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         i_target,
  input  logic               i_targetValid,
  input  logic [7:0]         i_switch,
  input  logic               i_submit,
  output logic               o_ready,
  output logic               o_resultValid,
  output logic               o_correct,
  output logic               o_invalidBcd,
  output logic [SCORE_W-1:0] o_score,
  output logic [6:0]         o_led
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;
  localparam logic [1:0] SHOW   = 2'd3;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SH_W = $clog2(SHOW_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SH_W-1:0] SH_LAST = SH_W'(SHOW_CYCLES - 1);

  logic [7:0]         r_swMeta;
  logic [7:0]         r_swSync;
  logic               r_subMeta;
  logic               r_subSync;
  logic [DB_W-1:0]    r_dbCnt;
  logic               r_dbLevel;
  logic               r_subPulse;
  logic [1:0]         r_state;
  logic [7:0]         r_target;
  logic [7:0]         r_entry;
  logic [SH_W-1:0]    r_showCnt;
  logic               r_resultValid;
  logic               r_correct;
  logic               r_invalidBcd;
  logic [SCORE_W-1:0] r_score;

  logic [3:0]         w_tens;
  logic [3:0]         w_units;
  logic               w_bad;
  logic [7:0]         w_val;
  logic               w_match;
  logic [6:0]         w_led;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_swMeta  <= '0;
      r_swSync  <= '0;
      r_subMeta <= 1'b0;
      r_subSync <= 1'b0;
    end else begin
      r_swMeta  <= i_switch;
      r_swSync  <= r_swMeta;
      r_subMeta <= i_submit;
      r_subSync <= r_subMeta;
    end
  end

  // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples; a rising move fires one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbCnt    <= '0;
      r_dbLevel  <= 1'b0;
      r_subPulse <= 1'b0;
    end else begin
      r_subPulse <= 1'b0;
      if (r_subSync == r_dbLevel) begin
        r_dbCnt <= '0;
      end else if (r_dbCnt == DB_LAST) begin
        r_dbCnt    <= '0;
        r_dbLevel  <= r_subSync;
        r_subPulse <= r_subSync;
      end else begin
        r_dbCnt <= r_dbCnt + DB_W'(1);
      end
    end
  end

  assign w_tens  = r_entry[7:4];
  assign w_units = r_entry[3:0];
  assign w_bad   = (w_tens > 4'd9) | (w_units > 4'd9);
  assign w_val   = {1'b0, w_tens, 3'b000} + {3'b000, w_tens, 1'b0} + {4'b0000, w_units};
  assign w_match = !w_bad && (w_val == r_target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_target      <= '0;
      r_entry       <= '0;
      r_showCnt     <= '0;
      r_resultValid <= 1'b0;
      r_correct     <= 1'b0;
      r_invalidBcd  <= 1'b0;
      r_score       <= '0;
    end else begin
      r_resultValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_targetValid) begin
            r_target <= i_target;
            r_state  <= ARMED;
          end
        end
        ARMED: begin
          if (r_subPulse) begin
            r_entry <= r_swSync;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          r_resultValid <= 1'b1;
          r_correct     <= w_match;
          r_invalidBcd  <= w_bad;
          if (w_match && (r_score != '1)) begin
            r_score <= r_score + SCORE_W'(1);
          end
          r_showCnt <= '0;
          r_state   <= SHOW;
        end
        default: begin
          // An invalid entry keeps the same target so the player can retry.
          if (r_showCnt == SH_LAST) begin
            r_state <= r_invalidBcd ? ARMED : IDLE;
          end else begin
            r_showCnt <= r_showCnt + SH_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    w_led = 7'b0000000;
    case (r_state)
      ARMED, DECODE: w_led = 7'b0000001;
      SHOW: begin
        if (r_invalidBcd)   w_led = 7'b0110011;
        else if (r_correct) w_led = 7'h7F;
        else                w_led = 7'b1010101;
      end
      default: w_led = 7'b0000000;
    endcase
  end

  assign o_ready       = (r_state == IDLE);
  assign o_resultValid = r_resultValid;
  assign o_correct     = r_correct;
  assign o_invalidBcd  = r_invalidBcd;
  assign o_score       = r_score;
  assign o_led         = w_led;

endmodule

// File: tb/tb_answer_checker.sv
// Directed bench for answer_checker; a second instance with a 2-bit score exercises saturation.
module tb_answer_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] target;
  logic       targetValid;
  logic [7:0] switchIn;
  logic       submit;

  logic       ready, resultValid, correct, invalidBcd;
  logic [6:0] score;
  logic [6:0] led;
  logic       satReady, satResultValid, satCorrect, satInvalidBcd;
  logic [1:0] satScore;
  logic [6:0] satLed;

  int checkCount = 0;
  int errorCount = 0;
  int rvCount = 0;
  int expScore = 0;
  int expSat = 0;

  always #5 clk = ~clk;

  answer_checker dut (
    .clk(clk), .rst(rst), .i_target(target), .i_targetValid(targetValid),
    .i_switch(switchIn), .i_submit(submit), .o_ready(ready),
    .o_resultValid(resultValid), .o_correct(correct), .o_invalidBcd(invalidBcd),
    .o_score(score), .o_led(led)
  );

  answer_checker #(.SCORE_W(2)) dutSat (
    .clk(clk), .rst(rst), .i_target(target), .i_targetValid(targetValid),
    .i_switch(switchIn), .i_submit(submit), .o_ready(satReady),
    .o_resultValid(satResultValid), .o_correct(satCorrect), .o_invalidBcd(satInvalidBcd),
    .o_score(satScore), .o_led(satLed)
  );

  always @(negedge clk) begin
    if (resultValid) rvCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full answer round: optional target load, clean press, verdict timing, SHOW hold and exit.
  task automatic applyStimulus(input string tag, input bit loadTarget, input logic [7:0] tgt,
                               input logic [7:0] sw, input bit expCorrect, input bit expInvalid);
    logic [6:0] expLed;
    expLed = expInvalid ? 7'b0110011 : (expCorrect ? 7'h7F : 7'b1010101);
    if (expCorrect) begin
      expScore++;
      if (expSat < 3) expSat++;
    end
    if (loadTarget) begin
      target = tgt;
      targetValid = 1'b1;
      tick(1);
      targetValid = 1'b0;
      checkOutput({tag, ".armedReady"}, ready, 0);
      checkOutput({tag, ".armedLed"}, led, 7'b0000001);
    end
    switchIn = sw;
    submit = 1'b1;
    tick(7);
    checkOutput({tag, ".rvEarly"}, resultValid, 0);
    switchIn = 8'h99;
    tick(1);
    checkOutput({tag, ".rv"}, resultValid, 1);
    checkOutput({tag, ".correct"}, correct, expCorrect);
    checkOutput({tag, ".invalid"}, invalidBcd, expInvalid);
    checkOutput({tag, ".score"}, score, expScore);
    checkOutput({tag, ".satScore"}, satScore, expSat);
    checkOutput({tag, ".ledShow"}, led, expLed);
    tick(1);
    checkOutput({tag, ".rvPulse"}, resultValid, 0);
    tick(6);
    checkOutput({tag, ".ledHold"}, led, expLed);
    tick(1);
    checkOutput({tag, ".exitReady"}, ready, expInvalid ? 0 : 1);
    checkOutput({tag, ".exitLed"}, led, expInvalid ? 7'b0000001 : 7'b0000000);
    submit = 1'b0;
    tick(8);
  endtask

  initial begin
    int rvBefore;
    rst = 1'b1;
    target = '0;
    targetValid = 1'b0;
    switchIn = '0;
    submit = 1'b0;
    tick(2);
    checkOutput("rst.ready", ready, 1);
    checkOutput("rst.rv", resultValid, 0);
    checkOutput("rst.correct", correct, 0);
    checkOutput("rst.invalid", invalidBcd, 0);
    checkOutput("rst.score", score, 0);
    checkOutput("rst.led", led, 0);
    rst = 1'b0;
    tick(2);

    applyStimulus("correct47", 1'b1, 8'd47, 8'h47, 1'b1, 1'b0);
    applyStimulus("correct12", 1'b1, 8'd12, 8'h12, 1'b1, 1'b0);
    applyStimulus("correct99", 1'b1, 8'd99, 8'h99, 1'b1, 1'b0);
    applyStimulus("correct00", 1'b1, 8'd0,  8'h00, 1'b1, 1'b0);
    applyStimulus("wrong23",   1'b1, 8'd23, 8'h32, 1'b0, 1'b0);
    applyStimulus("invalid0A", 1'b1, 8'd5,  8'h0A, 1'b0, 1'b1);
    applyStimulus("retry05",   1'b0, 8'd5,  8'h05, 1'b1, 1'b0);
    applyStimulus("tgt150",    1'b1, 8'd150, 8'h99, 1'b0, 1'b0);

    target = 8'd12;
    targetValid = 1'b1;
    tick(1);
    targetValid = 1'b0;
    switchIn = 8'h12;
    rvBefore = rvCount;
    for (int i = 0; i < 10; i++) begin
      submit = (i % 2 == 0);
      tick(1);
    end
    submit = 1'b1;
    tick(20);
    expScore++;
    checkOutput("bounce.pulses", rvCount - rvBefore, 1);
    checkOutput("bounce.correct", correct, 1);
    checkOutput("bounce.score", score, expScore);
    checkOutput("bounce.ready", ready, 1);

    target = 8'd30;
    targetValid = 1'b1;
    tick(1);
    targetValid = 1'b0;
    rvBefore = rvCount;
    tick(12);
    checkOutput("hold.pulses", rvCount - rvBefore, 0);
    checkOutput("hold.armed", ready, 0);

    submit = 1'b0;
    tick(8);
    switchIn = 8'h30;
    submit = 1'b1;
    rvBefore = rvCount;
    tick(7);
    rst = 1'b1;
    #1;
    checkOutput("abort.rv", resultValid, 0);
    checkOutput("abort.ready", ready, 1);
    checkOutput("abort.led", led, 0);
    checkOutput("abort.score", score, 0);
    checkOutput("abort.correct", correct, 0);
    checkOutput("abort.satScore", satScore, 0);
    tick(1);
    submit = 1'b0;
    checkOutput("abort.rvHeld", resultValid, 0);
    rst = 1'b0;
    tick(3);
    checkOutput("abort.idle", ready, 1);
    checkOutput("abort.noVerdict", rvCount - rvBefore, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
